tx_pkt_read_arbiter: RTL and testbench

- Shares the single packet-buffer read interface (raddr/rd/ack request plus 134-bit data return) between the two network transmit ports, port0 and port1.
- Arbitration is round-robin and packet-granular. The grant is held from address issue until the packet tail word is returned, and returned data is steered only to the owning port.
- Sits between the network transmit process and the packet buffer in the TSN NIC transmit path.

---
 rtl/tx_pkt_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_tx_pkt_read_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_read_arbiter.sv
// Round-robin, packet-granular arbiter sharing one packet-buffer read port
// between two transmit ports; returned words are steered to the grant owner.
module tx_pkt_read_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [15:0]   iv_pkt_raddr_p0,
   input  logic          i_pkt_rd_p0,
   output logic          o_pkt_raddr_ack_p0,
   output logic [133:0]  ov_pkt_data_p0,
   output logic          o_pkt_data_wr_p0,
   input  logic [15:0]   iv_pkt_raddr_p1,
   input  logic          i_pkt_rd_p1,
   output logic          o_pkt_raddr_ack_p1,
   output logic [133:0]  ov_pkt_data_p1,
   output logic          o_pkt_data_wr_p1,
   output logic [15:0]   ov_pkt_raddr,
   output logic          o_pkt_rd,
   input  logic          i_pkt_raddr_ack,
   input  logic [133:0]  iv_pkt_data,
   input  logic          i_pkt_data_wr,
   output logic          o_timeout_pulse,
   output logic          o_stray_data_pulse,
   output logic [1:0]    ov_arb_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic             r_owner, w_owner_nxt;
   logic             r_last_grant, w_last_grant_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [15:0]      r_raddr, w_raddr_nxt;
   logic             r_rd, w_rd_nxt;
   logic             r_ack_p0, w_ack_p0_nxt;
   logic             r_ack_p1, w_ack_p1_nxt;
   logic [133:0]     r_data_p0, w_data_p0_nxt;
   logic [133:0]     r_data_p1, w_data_p1_nxt;
   logic             r_wr_p0, w_wr_p0_nxt;
   logic             r_wr_p1, w_wr_p1_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             r_stray, w_stray_nxt;
   logic             w_grant;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      w_raddr_nxt      = r_raddr;
      w_rd_nxt         = r_rd;
      w_ack_p0_nxt     = 1'b0;
      w_ack_p1_nxt     = 1'b0;
      w_data_p0_nxt    = '0;
      w_data_p1_nxt    = '0;
      w_wr_p0_nxt      = 1'b0;
      w_wr_p1_nxt      = 1'b0;
      w_timeout_nxt    = 1'b0;
      w_stray_nxt      = 1'b0;
      w_grant          = 1'b0;

      case (r_state)
         IDLE: begin
            w_stray_nxt = i_pkt_data_wr;
            if (i_pkt_rd_p0 || i_pkt_rd_p1) begin
               // On contention the port that did not win last time goes next.
               w_grant          = (i_pkt_rd_p0 && i_pkt_rd_p1) ? ~r_last_grant : i_pkt_rd_p1;
               w_owner_nxt      = w_grant;
               w_last_grant_nxt = w_grant;
               w_raddr_nxt      = w_grant ? iv_pkt_raddr_p1 : iv_pkt_raddr_p0;
               w_rd_nxt         = 1'b1;
               w_state_nxt      = ISSUE;
            end
         end

         ISSUE: begin
            w_stray_nxt = i_pkt_data_wr;
            if (i_pkt_raddr_ack) begin
               w_rd_nxt     = 1'b0;
               w_ack_p0_nxt = ~r_owner;
               w_ack_p1_nxt = r_owner;
               w_cnt_nxt    = '0;
               w_state_nxt  = WAIT_DATA;
            end
         end

         WAIT_DATA: begin
            if (i_pkt_data_wr) begin
               w_cnt_nxt = '0;
               if (r_owner) begin
                  w_data_p1_nxt = iv_pkt_data;
                  w_wr_p1_nxt   = 1'b1;
               end else begin
                  w_data_p0_nxt = iv_pkt_data;
                  w_wr_p0_nxt   = 1'b1;
               end
               // Type 10 (tail) and 11 (single word) both end the packet.
               if (iv_pkt_data[133]) w_state_nxt = IDLE;
            end else if (r_cnt == LP_CNT_MAX) begin
               w_state_nxt   = IDLE;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_raddr      <= '0;
         r_rd         <= 1'b0;
         r_ack_p0     <= 1'b0;
         r_ack_p1     <= 1'b0;
         r_data_p0    <= '0;
         r_data_p1    <= '0;
         r_wr_p0      <= 1'b0;
         r_wr_p1      <= 1'b0;
         r_timeout    <= 1'b0;
         r_stray      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together from pre-edge values.
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
         r_raddr      <= w_raddr_nxt;
         r_rd         <= w_rd_nxt;
         r_ack_p0     <= w_ack_p0_nxt;
         r_ack_p1     <= w_ack_p1_nxt;
         r_data_p0    <= w_data_p0_nxt;
         r_data_p1    <= w_data_p1_nxt;
         r_wr_p0      <= w_wr_p0_nxt;
         r_wr_p1      <= w_wr_p1_nxt;
         r_timeout    <= w_timeout_nxt;
         r_stray      <= w_stray_nxt;
      end
   end

   assign ov_pkt_raddr       = r_raddr;
   assign o_pkt_rd           = r_rd;
   assign o_pkt_raddr_ack_p0 = r_ack_p0;
   assign o_pkt_raddr_ack_p1 = r_ack_p1;
   assign ov_pkt_data_p0     = r_data_p0;
   assign ov_pkt_data_p1     = r_data_p1;
   assign o_pkt_data_wr_p0   = r_wr_p0;
   assign o_pkt_data_wr_p1   = r_wr_p1;
   assign o_timeout_pulse    = r_timeout;
   assign o_stray_data_pulse = r_stray;
   assign ov_arb_state       = r_state;

endmodule

// File: tb/tb_tx_pkt_read_arbiter.sv
// Directed self-checking bench for tx_pkt_read_arbiter; timeout shortened to
// 16 cycles so the forced-release path is exercised quickly.
module tb_tx_pkt_read_arbiter;

   logic          clk;
   logic          rst_n;
   logic [15:0]   raddr_p0, raddr_p1;
   logic          rd_p0, rd_p1;
   logic          ack_p0, ack_p1;
   logic [133:0]  data_p0, data_p1;
   logic          wr_p0, wr_p1;
   logic [15:0]   raddr;
   logic          rd;
   logic          raddr_ack;
   logic [133:0]  data_in;
   logic          data_wr;
   logic          timeout_pulse;
   logic          stray_pulse;
   logic [1:0]    arb_state;

   int n_checks;
   int n_errors;

   tx_pkt_read_arbiter #(
      .TIMEOUT_CYCLES (16),
      .CNT_W          (5)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .iv_pkt_raddr_p0    (raddr_p0),
      .i_pkt_rd_p0        (rd_p0),
      .o_pkt_raddr_ack_p0 (ack_p0),
      .ov_pkt_data_p0     (data_p0),
      .o_pkt_data_wr_p0   (wr_p0),
      .iv_pkt_raddr_p1    (raddr_p1),
      .i_pkt_rd_p1        (rd_p1),
      .o_pkt_raddr_ack_p1 (ack_p1),
      .ov_pkt_data_p1     (data_p1),
      .o_pkt_data_wr_p1   (wr_p1),
      .ov_pkt_raddr       (raddr),
      .o_pkt_rd           (rd),
      .i_pkt_raddr_ack    (raddr_ack),
      .iv_pkt_data        (data_in),
      .i_pkt_data_wr      (data_wr),
      .o_timeout_pulse    (timeout_pulse),
      .o_stray_data_pulse (stray_pulse),
      .ov_arb_state       (arb_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [133:0] mk_word(input logic [1:0] t, input logic [31:0] tag);
      return {t, 4'hA, tag, ~tag, tag ^ 32'h5A5A_5A5A, tag + 32'd7};
   endfunction

   // Inputs driven before a step take effect at that edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      raddr_p0 = '0; raddr_p1 = '0; rd_p0 = 1'b0; rd_p1 = 1'b0;
      raddr_ack = 1'b0; data_in = '0; data_wr = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #12;
      n_checks++;
      if ({rd, ack_p0, ack_p1, wr_p0, wr_p1, timeout_pulse, stray_pulse} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {rd, ack_p0, ack_p1, wr_p0, wr_p1, timeout_pulse, stray_pulse});
      end
      n_checks++;
      if (raddr !== 16'h0 || data_p0 !== '0 || data_p1 !== '0 || arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_data: raddr=%h state=%0d want 0/0", raddr, arb_state);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      n_checks++;
      if (arb_state !== 2'd0 || rd !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: state=%0d rd=%b want 0/0", arb_state, rd);
      end
   endtask

   task automatic test_single_packet();
      logic [1:0] types [3];
      logic [133:0] w;
      types[0] = 2'b01; types[1] = 2'b00; types[2] = 2'b10;
      rd_p0 = 1'b1; raddr_p0 = 16'h0010;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0010 || arb_state !== 2'd1) begin
         n_errors++;
         $display("FAIL t1_issue: rd=%b raddr=%h state=%0d want 1/0010/1", rd, raddr, arb_state);
      end
      step();
      n_checks++;
      if (rd !== 1'b1 || ack_p0 !== 1'b0) begin
         n_errors++;
         $display("FAIL t1_hold: rd=%b ack_p0=%b want 1/0", rd, ack_p0);
      end
      raddr_ack = 1'b1;
      step();
      n_checks++;
      if (rd !== 1'b0 || ack_p0 !== 1'b1 || ack_p1 !== 1'b0 || arb_state !== 2'd2) begin
         n_errors++;
         $display("FAIL t1_ack: rd=%b ack_p0=%b ack_p1=%b state=%0d want 0/1/0/2",
                  rd, ack_p0, ack_p1, arb_state);
      end
      raddr_ack = 1'b0; rd_p0 = 1'b0;
      step();
      n_checks++;
      if (ack_p0 !== 1'b0) begin
         n_errors++;
         $display("FAIL t1_ack_once: ack_p0=%b want 0", ack_p0);
      end
      for (int i = 0; i < 3; i++) begin
         w = mk_word(types[i], 32'h1111_0000 + 32'(i));
         data_in = w; data_wr = 1'b1;
         step();
         n_checks++;
         if (wr_p0 !== 1'b1 || data_p0 !== w || wr_p1 !== 1'b0 || data_p1 !== '0) begin
            n_errors++;
            $display("FAIL t1_word%0d: wr_p0=%b wr_p1=%b data_p0=%h want 1/0/%h",
                     i, wr_p0, wr_p1, data_p0, w);
         end
      end
      n_checks++;
      if (arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL t1_idle: state=%0d want 0", arb_state);
      end
      data_wr = 1'b0; data_in = '0;
      step();
      n_checks++;
      if (wr_p0 !== 1'b0 || data_p0 !== '0) begin
         n_errors++;
         $display("FAIL t1_quiet: wr_p0=%b want 0", wr_p0);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      rd_p0 = 1'b1; rd_p1 = 1'b1; raddr_p0 = 16'h0100; raddr_p1 = 16'h0200;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0100) begin
         n_errors++;
         $display("FAIL t2_first: rd=%b raddr=%h want 1/0100", rd, raddr);
      end
      raddr_ack = 1'b1;
      step();
      n_checks++;
      if (ack_p0 !== 1'b1 || ack_p1 !== 1'b0) begin
         n_errors++;
         $display("FAIL t2_ack0: ack_p0=%b ack_p1=%b want 1/0", ack_p0, ack_p1);
      end
      raddr_ack = 1'b0; rd_p0 = 1'b0;
      data_in = mk_word(2'b01, 32'h2222_0001); data_wr = 1'b1;
      step();
      data_in = mk_word(2'b10, 32'h2222_0002);
      step();
      n_checks++;
      if (wr_p0 !== 1'b1 || wr_p1 !== 1'b0 || arb_state !== 2'd0 || rd !== 1'b0) begin
         n_errors++;
         $display("FAIL t2_tail: wr_p0=%b wr_p1=%b state=%0d rd=%b want 1/0/0/0",
                  wr_p0, wr_p1, arb_state, rd);
      end
      data_wr = 1'b0; data_in = '0;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0200) begin
         n_errors++;
         $display("FAIL t2_second: rd=%b raddr=%h want 1/0200", rd, raddr);
      end
      raddr_ack = 1'b1;
      step();
      n_checks++;
      if (ack_p1 !== 1'b1 || ack_p0 !== 1'b0) begin
         n_errors++;
         $display("FAIL t2_ack1: ack_p1=%b ack_p0=%b want 1/0", ack_p1, ack_p0);
      end
      raddr_ack = 1'b0;
      rd_p0 = 1'b1; raddr_p0 = 16'h0300;
      data_in = mk_word(2'b10, 32'h2222_0003); data_wr = 1'b1;
      step();
      n_checks++;
      if (wr_p1 !== 1'b1 || wr_p0 !== 1'b0 || data_p0 !== '0) begin
         n_errors++;
         $display("FAIL t2_p1_tail: wr_p1=%b wr_p0=%b want 1/0", wr_p1, wr_p0);
      end
      data_wr = 1'b0; data_in = '0;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0300) begin
         n_errors++;
         $display("FAIL t2_alternate: rd=%b raddr=%h want 1/0300", rd, raddr);
      end
      raddr_ack = 1'b1;
      step();
      raddr_ack = 1'b0; rd_p0 = 1'b0; rd_p1 = 1'b0;
      data_in = mk_word(2'b11, 32'h2222_0004); data_wr = 1'b1;
      step();
      data_wr = 1'b0; data_in = '0;
   endtask

   task automatic test_single_word();
      logic [133:0] w;
      rd_p1 = 1'b1; raddr_p1 = 16'h0400;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0400) begin
         n_errors++;
         $display("FAIL t3_issue: rd=%b raddr=%h want 1/0400", rd, raddr);
      end
      raddr_ack = 1'b1;
      step();
      raddr_ack = 1'b0; rd_p1 = 1'b0;
      w = mk_word(2'b11, 32'h3333_0001);
      data_in = w; data_wr = 1'b1;
      step();
      n_checks++;
      if (wr_p1 !== 1'b1 || data_p1 !== w || wr_p0 !== 1'b0 || arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL t3_word: wr_p1=%b wr_p0=%b state=%0d data_p1=%h want 1/0/0/%h",
                  wr_p1, wr_p0, arb_state, data_p1, w);
      end
      data_wr = 1'b0; data_in = '0;
      step();
      n_checks++;
      if (wr_p1 !== 1'b0 || data_p1 !== '0) begin
         n_errors++;
         $display("FAIL t3_once: wr_p1=%b want 0", wr_p1);
      end
   endtask

   task automatic test_timeout();
      int early;
      rd_p0 = 1'b1; raddr_p0 = 16'h0500;
      step();
      raddr_ack = 1'b1;
      step();
      n_checks++;
      if (arb_state !== 2'd2) begin
         n_errors++;
         $display("FAIL t4_wait: state=%0d want 2", arb_state);
      end
      raddr_ack = 1'b0; rd_p0 = 1'b0;
      rd_p1 = 1'b1; raddr_p1 = 16'h0600;
      early = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         if (timeout_pulse !== 1'b0 || arb_state !== 2'd2) early++;
      end
      n_checks++;
      if (early != 0) begin
         n_errors++;
         $display("FAIL t4_early: %0d premature cycles want 0", early);
      end
      step();
      n_checks++;
      if (timeout_pulse !== 1'b1 || arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL t4_pulse: timeout=%b state=%0d want 1/0", timeout_pulse, arb_state);
      end
      step();
      n_checks++;
      if (timeout_pulse !== 1'b0 || rd !== 1'b1 || raddr !== 16'h0600) begin
         n_errors++;
         $display("FAIL t4_regrant: timeout=%b rd=%b raddr=%h want 0/1/0600",
                  timeout_pulse, rd, raddr);
      end
      raddr_ack = 1'b1;
      step();
      raddr_ack = 1'b0; rd_p1 = 1'b0;
      data_in = mk_word(2'b11, 32'h4444_0001); data_wr = 1'b1;
      step();
      data_wr = 1'b0; data_in = '0;
   endtask

   task automatic test_stray_and_ack();
      data_in = mk_word(2'b01, 32'h5555_0001); data_wr = 1'b1;
      step();
      n_checks++;
      if (stray_pulse !== 1'b1 || wr_p0 !== 1'b0 || wr_p1 !== 1'b0) begin
         n_errors++;
         $display("FAIL t5_stray: stray=%b wr_p0=%b wr_p1=%b want 1/0/0", stray_pulse, wr_p0, wr_p1);
      end
      data_wr = 1'b0; data_in = '0; raddr_ack = 1'b1;
      step();
      n_checks++;
      if (stray_pulse !== 1'b0 || ack_p0 !== 1'b0 || ack_p1 !== 1'b0 || arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL t5_ack_idle: stray=%b ack_p0=%b ack_p1=%b state=%0d want 0/0/0/0",
                  stray_pulse, ack_p0, ack_p1, arb_state);
      end
      raddr_ack = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      rd_p0 = 1'b1; raddr_p0 = 16'h0700;
      step();
      raddr_ack = 1'b1;
      step();
      raddr_ack = 1'b0; rd_p0 = 1'b0;
      data_in = mk_word(2'b01, 32'h6666_0001); data_wr = 1'b1;
      step();
      n_checks++;
      if (wr_p0 !== 1'b1) begin
         n_errors++;
         $display("FAIL t6_pre: wr_p0=%b want 1", wr_p0);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({wr_p0, rd, ack_p0, timeout_pulse, stray_pulse} !== 5'b0 || data_p0 !== '0 ||
          arb_state !== 2'd0) begin
         n_errors++;
         $display("FAIL t6_async: wr_p0=%b rd=%b timeout=%b stray=%b state=%0d want all 0",
                  wr_p0, rd, timeout_pulse, stray_pulse, arb_state);
      end
      clear_inputs();
      step();
      rst_n = 1'b1;
      rd_p0 = 1'b1; rd_p1 = 1'b1; raddr_p0 = 16'h0800; raddr_p1 = 16'h0900;
      step();
      n_checks++;
      if (rd !== 1'b1 || raddr !== 16'h0800 || timeout_pulse !== 1'b0 || stray_pulse !== 1'b0) begin
         n_errors++;
         $display("FAIL t6_regrant: rd=%b raddr=%h want 1/0800", rd, raddr);
      end
      clear_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_single_word();
      test_timeout();
      test_stray_and_ack();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
